// File: rtl/kernel_dma_shell.sv
// rtl/kernel_dma_shell.sv - streaming DMA shell around an HLS kernel with a local dual-port buffer
//
// Loads num_read words from the read channel into a 2^ADDR_WID-word buffer,
// pulses k_start, serves the kernel's two buffer ports until k_done (or the
// optional run timeout), then streams num_write words back out on the write
// channel. done pulses once per job; error pulses with it when the job failed.
//
// Ports:
//   clk, reset_n                   clock, synchronous active-low reset
//   start + job inputs             job request and parameters, latched in IDLE
//   read_* / finish_read           read channel (read_ready accepts read_data)
//   write_* / finish_write         write channel (write_ready accepts write_data)
//   done, error, busy, returnvalue job status and latched kernel result
//   k_start, k_done, k_ret         kernel control
//   k_addr*/k_ce*/k_we*/k_d*/k_q*  kernel buffer ports 0 and 1
module kernel_dma_shell #(
  parameter int DATA_WID = 32,
  parameter int ADDR_WID = 3,
  parameter int TIMEOUT  = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [63:0]         read_base,
  input  logic [63:0]         write_base,
  input  logic [63:0]         num_read,
  input  logic [63:0]         num_write,
  input  logic [63:0]         read_size_input,
  input  logic                read_ready,
  input  logic                write_ready,
  input  logic [DATA_WID-1:0] read_data,
  output logic                read_enable,
  output logic                write_enable,
  output logic                finish_read,
  output logic                finish_write,
  output logic [63:0]         read_addr,
  output logic [63:0]         write_addr,
  output logic [63:0]         write_size,
  output logic [63:0]         read_size_output,
  output logic [DATA_WID-1:0] write_data,
  output logic                done,
  output logic                error,
  output logic                busy,
  output logic [DATA_WID-1:0] returnvalue,
  output logic                k_start,
  input  logic                k_done,
  input  logic [DATA_WID-1:0] k_ret,
  input  logic [ADDR_WID-1:0] k_addr0,
  input  logic [ADDR_WID-1:0] k_addr1,
  input  logic                k_ce0,
  input  logic                k_ce1,
  input  logic                k_we0,
  input  logic                k_we1,
  input  logic [DATA_WID-1:0] k_d0,
  input  logic [DATA_WID-1:0] k_d1,
  output logic [DATA_WID-1:0] k_q0,
  output logic [DATA_WID-1:0] k_q1
);

  localparam int DEPTH = 1 << ADDR_WID;
  localparam logic [ADDR_WID:0] CNT_ONE = 1;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_CHECK   = 4'd1;
  localparam logic [3:0] S_RD_WAIT = 4'd2;
  localparam logic [3:0] S_RD_NEXT = 4'd3;
  localparam logic [3:0] S_K_START = 4'd4;
  localparam logic [3:0] S_K_RUN   = 4'd5;
  localparam logic [3:0] S_WR_LOAD = 4'd6;
  localparam logic [3:0] S_WR_WAIT = 4'd7;
  localparam logic [3:0] S_WR_NEXT = 4'd8;
  localparam logic [3:0] S_FIN     = 4'd9;

  logic [3:0]          state_q, state_d;
  logic [63:0]         read_base_q, read_base_d, write_base_q, write_base_d;
  logic [63:0]         num_read_q, num_read_d, num_write_q, num_write_d;
  logic [63:0]         stride_q, stride_d;
  logic [ADDR_WID:0]   cnt_q, cnt_d, cnt_next;
  logic [31:0]         run_q, run_d;
  logic                err_q, err_d;
  logic                read_enable_q, read_enable_d, write_enable_q, write_enable_d;
  logic                finish_read_q, finish_read_d, finish_write_q, finish_write_d;
  logic [63:0]         read_addr_q, read_addr_d, write_addr_q, write_addr_d;
  logic [63:0]         write_size_q, write_size_d, read_size_output_q, read_size_output_d;
  logic [DATA_WID-1:0] write_data_q, write_data_d, returnvalue_q, returnvalue_d;
  logic                done_q, done_d, error_q, error_d, k_start_q, k_start_d;
  logic [DATA_WID-1:0] k_q0_q, k_q0_d, k_q1_q, k_q1_d;
  logic                ld_we, k0_we, k1_we;

  // Buffer survives reset and jobs; only the load path and the kernel write it.
  logic [DATA_WID-1:0] mem_q [DEPTH];

  always_comb begin
    state_d            = state_q;
    read_base_d        = read_base_q;
    write_base_d       = write_base_q;
    num_read_d         = num_read_q;
    num_write_d        = num_write_q;
    stride_d           = stride_q;
    cnt_d              = cnt_q;
    run_d              = run_q;
    err_d              = err_q;
    read_enable_d      = read_enable_q;
    write_enable_d     = write_enable_q;
    finish_read_d      = finish_read_q;
    finish_write_d     = finish_write_q;
    read_addr_d        = read_addr_q;
    write_addr_d       = write_addr_q;
    write_size_d       = write_size_q;
    read_size_output_d = read_size_output_q;
    write_data_d       = write_data_q;
    returnvalue_d      = returnvalue_q;
    k_q0_d             = k_q0_q;
    k_q1_d             = k_q1_q;
    ld_we              = 1'b0;
    k0_we              = 1'b0;
    k1_we              = 1'b0;
    cnt_next           = cnt_q + CNT_ONE;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          read_base_d  = read_base;
          write_base_d = write_base;
          num_read_d   = num_read;
          num_write_d  = num_write;
          stride_d     = read_size_input;
          err_d        = 1'b0;
          state_d      = S_CHECK;
        end
      end
      S_CHECK: begin
        if ((num_read_q == '0) || (num_read_q > 64'(DEPTH)) || (num_write_q > 64'(DEPTH))) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          read_addr_d        = read_base_q;
          read_size_output_d = stride_q;
          read_enable_d      = 1'b1;
          cnt_d              = '0;
          state_d            = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        finish_read_d = 1'b0;
        if (read_ready) begin
          ld_we   = 1'b1;
          state_d = S_RD_NEXT;
        end
      end
      S_RD_NEXT: begin
        if (64'(cnt_next) < num_read_q) begin
          cnt_d         = cnt_next;
          read_addr_d   = read_addr_q + stride_q;
          finish_read_d = 1'b1;
          state_d       = S_RD_WAIT;
        end else begin
          read_enable_d = 1'b0;
          state_d       = S_K_START;
        end
      end
      S_K_START: begin
        run_d   = '0;
        state_d = S_K_RUN;
      end
      S_K_RUN: begin
        // A read that hits an address written this cycle sees the old word.
        if (k_ce0) begin
          if (k_we0) k0_we = 1'b1;
          else       k_q0_d = mem_q[k_addr0];
        end
        if (k_ce1) begin
          if (k_we1) k1_we = 1'b1;
          else       k_q1_d = mem_q[k_addr1];
        end
        if (k_done) begin
          returnvalue_d = k_ret;
          state_d       = (num_write_q == '0) ? S_FIN : S_WR_LOAD;
        end else if ((TIMEOUT != 0) && (run_q + 32'd1 == 32'(TIMEOUT))) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          run_d = run_q + 32'd1;
        end
      end
      S_WR_LOAD: begin
        write_addr_d   = write_base_q;
        write_size_d   = stride_q;
        write_data_d   = mem_q[0];
        write_enable_d = 1'b1;
        cnt_d          = '0;
        state_d        = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        finish_write_d = 1'b0;
        if (write_ready) state_d = S_WR_NEXT;
      end
      S_WR_NEXT: begin
        if (64'(cnt_next) < num_write_q) begin
          cnt_d          = cnt_next;
          write_data_d   = mem_q[cnt_next[ADDR_WID-1:0]];
          write_addr_d   = write_addr_q + stride_q;
          finish_write_d = 1'b1;
          state_d        = S_WR_WAIT;
        end else begin
          write_enable_d = 1'b0;
          state_d        = S_FIN;
        end
      end
      S_FIN: begin
        read_enable_d      = 1'b0;
        write_enable_d     = 1'b0;
        finish_read_d      = 1'b0;
        finish_write_d     = 1'b0;
        read_addr_d        = '0;
        write_addr_d       = '0;
        write_size_d       = '0;
        read_size_output_d = '0;
        write_data_d       = '0;
        state_d            = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Status strobes are registered so they are high exactly while in the target state.
    done_d    = (state_d == S_FIN);
    error_d   = done_d & err_d;
    k_start_d = (state_d == S_K_START);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q            <= S_IDLE;
      read_base_q        <= '0;
      write_base_q       <= '0;
      num_read_q         <= '0;
      num_write_q        <= '0;
      stride_q           <= '0;
      cnt_q              <= '0;
      run_q              <= '0;
      err_q              <= 1'b0;
      read_enable_q      <= 1'b0;
      write_enable_q     <= 1'b0;
      finish_read_q      <= 1'b0;
      finish_write_q     <= 1'b0;
      read_addr_q        <= '0;
      write_addr_q       <= '0;
      write_size_q       <= '0;
      read_size_output_q <= '0;
      write_data_q       <= '0;
      returnvalue_q      <= '0;
      done_q             <= 1'b0;
      error_q            <= 1'b0;
      k_start_q          <= 1'b0;
      k_q0_q             <= '0;
      k_q1_q             <= '0;
    end else begin
      state_q            <= state_d;
      read_base_q        <= read_base_d;
      write_base_q       <= write_base_d;
      num_read_q         <= num_read_d;
      num_write_q        <= num_write_d;
      stride_q           <= stride_d;
      cnt_q              <= cnt_d;
      run_q              <= run_d;
      err_q              <= err_d;
      read_enable_q      <= read_enable_d;
      write_enable_q     <= write_enable_d;
      finish_read_q      <= finish_read_d;
      finish_write_q     <= finish_write_d;
      read_addr_q        <= read_addr_d;
      write_addr_q       <= write_addr_d;
      write_size_q       <= write_size_d;
      read_size_output_q <= read_size_output_d;
      write_data_q       <= write_data_d;
      returnvalue_q      <= returnvalue_d;
      done_q             <= done_d;
      error_q            <= error_d;
      k_start_q          <= k_start_d;
      k_q0_q             <= k_q0_d;
      k_q1_q             <= k_q1_d;
    end
  end

  // Port 1 is written last so it wins a same-address collision with port 0.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (ld_we) mem_q[cnt_q[ADDR_WID-1:0]] <= read_data;
      if (k0_we) mem_q[k_addr0] <= k_d0;
      if (k1_we) mem_q[k_addr1] <= k_d1;
    end
  end

  assign read_enable      = read_enable_q;
  assign write_enable     = write_enable_q;
  assign finish_read      = finish_read_q;
  assign finish_write     = finish_write_q;
  assign read_addr        = read_addr_q;
  assign write_addr       = write_addr_q;
  assign write_size       = write_size_q;
  assign read_size_output = read_size_output_q;
  assign write_data       = write_data_q;
  assign done             = done_q;
  assign error            = error_q;
  assign busy             = (state_q != S_IDLE);
  assign returnvalue      = returnvalue_q;
  assign k_start          = k_start_q;
  assign k_q0             = k_q0_q;
  assign k_q1             = k_q1_q;

endmodule

// File: tb/tb_kernel_dma_shell.sv
// tb/tb_kernel_dma_shell.sv - scoreboard testbench for kernel_dma_shell
module tb_kernel_dma_shell;

  localparam int DW = 32;
  localparam int AW = 3;
  localparam int TO = 50;
  localparam int KM_INC = 0, KM_NEVER = 1, KM_DUAL = 2, KM_RET = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [63:0]   read_base = '0, write_base = '0, num_read = '0, num_write = '0, read_size_input = '0;
  logic          read_ready = 1'b0, write_ready = 1'b0;
  logic [DW-1:0] read_data = '0;
  logic          read_enable, write_enable, finish_read, finish_write;
  logic [63:0]   read_addr, write_addr, write_size, read_size_output;
  logic [DW-1:0] write_data, returnvalue, k_q0, k_q1;
  logic          done, error, busy, k_start;
  logic          k_done = 1'b0;
  logic [DW-1:0] k_ret = '0, k_d0 = '0, k_d1 = '0;
  logic [AW-1:0] k_addr0 = '0, k_addr1 = '0;
  logic          k_ce0 = 1'b0, k_ce1 = 1'b0, k_we0 = 1'b0, k_we1 = 1'b0;

  kernel_dma_shell #(.DATA_WID(DW), .ADDR_WID(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .read_base(read_base), .write_base(write_base), .num_read(num_read), .num_write(num_write),
    .read_size_input(read_size_input), .read_ready(read_ready), .write_ready(write_ready),
    .read_data(read_data), .read_enable(read_enable), .write_enable(write_enable),
    .finish_read(finish_read), .finish_write(finish_write), .read_addr(read_addr),
    .write_addr(write_addr), .write_size(write_size), .read_size_output(read_size_output),
    .write_data(write_data), .done(done), .error(error), .busy(busy), .returnvalue(returnvalue),
    .k_start(k_start), .k_done(k_done), .k_ret(k_ret), .k_addr0(k_addr0), .k_addr1(k_addr1),
    .k_ce0(k_ce0), .k_ce1(k_ce1), .k_we0(k_we0), .k_we1(k_we1), .k_d0(k_d0), .k_d1(k_d1),
    .k_q0(k_q0), .k_q1(k_q1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model [8];
  logic [DW-1:0] last_ret = '0;

  int j_done_cyc, j_err, j_first_rd, j_kstart_cyc, j_kdone_cyc, j_last_wr;
  int j_we_seen, j_fr_cnt, j_fw_cnt, j_ks_cnt, j_wr_cnt, j_aborted;

  task automatic run_job(input logic [63:0] rb, input logic [63:0] wb, input logic [63:0] nr,
                         input logic [63:0] nw, input logic [63:0] st, input int kmode,
                         input logic [DW-1:0] kret, input int abort_rd);
    int cyc, rd_idx, wr_idx, kph, ki;
    bit rr_last, wr_last, kread;
    logic [DW-1:0] w, exp_w;
    j_done_cyc = -1; j_err = -1; j_first_rd = -1; j_kstart_cyc = -1; j_kdone_cyc = -1;
    j_last_wr = -1; j_we_seen = 0; j_fr_cnt = 0; j_fw_cnt = 0; j_ks_cnt = 0; j_wr_cnt = 0;
    j_aborted = 0;
    rd_idx = 0; wr_idx = 0; kph = 0; ki = 0; rr_last = 0; wr_last = 0; kread = 0;
    @(negedge clk);
    read_base = rb; write_base = wb; num_read = nr; num_write = nw; read_size_input = st;
    start = 1'b1;
    cyc = 0;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      read_ready = 1'b0; write_ready = 1'b0; k_done = 1'b0;
      k_ce0 = 1'b0; k_ce1 = 1'b0; k_we0 = 1'b0; k_we1 = 1'b0;
      if (done) begin
        j_done_cyc = cyc;
        j_err = int'(error);
        break;
      end
      if (cyc == 1) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %b expected 1", busy); end
      end
      if (read_enable && j_first_rd < 0) j_first_rd = cyc;
      if (write_enable) j_we_seen = 1;
      if (finish_read) j_fr_cnt++;
      if (finish_write) j_fw_cnt++;
      if (k_start) j_ks_cnt++;

      // read channel responder, never two ready cycles in a row
      if (read_enable && !rr_last) begin
        if (abort_rd > 0 && rd_idx == abort_rd) begin
          reset_n = 1'b0;
          j_aborted = 1;
          break;
        end else if ($urandom_range(3) != 0) begin
          checks++;
          if (read_addr !== rb + st * 64'(rd_idx) || read_size_output !== st) begin
            errors++;
            $display("FAIL rd_addr[%0d]: got %h/%h expected %h/%h", rd_idx, read_addr,
                     read_size_output, rb + st * 64'(rd_idx), st);
          end
          w = $urandom;
          read_data = w;
          read_ready = 1'b1;
          model[rd_idx] = w;
          rd_idx++;
        end
      end
      rr_last = read_ready;

      // write channel collector against the scoreboard
      if (write_enable && !wr_last && $urandom_range(3) != 0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected[%0d]: got %h expected no write", wr_idx, write_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (write_data !== exp_w || write_addr !== wb + st * 64'(wr_idx) || write_size !== st) begin
            errors++;
            $display("FAIL wr_word[%0d]: got data %h addr %h size %h expected data %h addr %h size %h",
                     wr_idx, write_data, write_addr, write_size, exp_w, wb + st * 64'(wr_idx), st);
          end
        end
        write_ready = 1'b1;
        wr_idx++;
        j_wr_cnt++;
        j_last_wr = cyc;
      end
      wr_last = write_ready;

      // kernel model
      if (kph == 0 && k_start) begin
        kph = 1;
        j_kstart_cyc = cyc;
      end else if (kph == 1) begin
        if ((kmode == KM_INC && ki >= int'(nr)) || (kmode == KM_DUAL && ki == 1) || kmode == KM_RET) begin
          k_done = 1'b1;
          k_ret = kret;
          last_ret = kret;
          j_kdone_cyc = cyc;
          for (int i = 0; i < int'(nw); i++) exp_q.push_back(model[i]);
          kph = 2;
        end else if (kmode == KM_INC) begin
          if (!kread) begin
            k_ce0 = 1'b1; k_addr0 = AW'(ki);
            kread = 1;
          end else begin
            checks++;
            if (k_q0 !== model[ki]) begin
              errors++;
              $display("FAIL k_q0[%0d]: got %h expected %h", ki, k_q0, model[ki]);
            end
            model[ki] = model[ki] + 1;
            k_ce1 = 1'b1; k_we1 = 1'b1; k_addr1 = AW'(ki); k_d1 = model[ki];
            kread = 0;
            ki++;
          end
        end else if (kmode == KM_DUAL) begin
          k_ce0 = 1'b1; k_we0 = 1'b1; k_addr0 = 3'd3; k_d0 = 32'hAAAA_0003;
          k_ce1 = 1'b1; k_we1 = 1'b1; k_addr1 = 3'd3; k_d1 = 32'hBBBB_0003;
          model[3] = 32'hBBBB_0003;
          ki = 1;
        end
      end
    end
    read_ready = 1'b0; write_ready = 1'b0; k_done = 1'b0;
    k_ce0 = 1'b0; k_ce1 = 1'b0; k_we0 = 1'b0; k_we1 = 1'b0;
    if (j_aborted != 0) return;
    checks++;
    if (j_done_cyc < 0) begin
      errors++;
      $display("FAIL job_timeout: got no done expected done within 3000 cycles");
      return;
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || read_enable !== 1'b0 || write_enable !== 1'b0 ||
        read_addr !== '0 || write_addr !== '0) begin
      errors++;
      $display("FAIL idle_after_fin: got done %b busy %b re %b we %b ra %h wa %h expected all 0",
               done, busy, read_enable, write_enable, read_addr, write_addr);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({read_enable, write_enable, finish_read, finish_write, done, error, busy, k_start} !== 8'h0 ||
        {read_addr, write_addr, write_size, read_size_output} !== 256'h0 ||
        {write_data, returnvalue, k_q0, k_q1} !== 128'h0) begin
      errors++;
      $display("FAIL reset_state: got nonzero outputs expected all 0");
    end
    reset_n = 1'b1;
    last_ret = '0;
  endtask

  task automatic test_full_job;
    run_job(64'h1000, 64'h8000, 8, 8, 4, KM_INC, 32'hCAFE_0001, 0);
    checks++;
    if (j_err !== 0 || j_wr_cnt != 8) begin
      errors++; $display("FAIL full_status: got err %0d writes %0d expected 0 8", j_err, j_wr_cnt);
    end
    checks++;
    if (j_first_rd != 2) begin
      errors++; $display("FAIL first_read_latency: got %0d expected 2", j_first_rd);
    end
    checks++;
    if (j_done_cyc != j_last_wr + 2) begin
      errors++; $display("FAIL done_after_write: got %0d expected %0d", j_done_cyc, j_last_wr + 2);
    end
    checks++;
    if (j_fr_cnt != 7 || j_fw_cnt != 7 || j_ks_cnt != 1) begin
      errors++;
      $display("FAIL pulse_counts: got fr %0d fw %0d ks %0d expected 7 7 1", j_fr_cnt, j_fw_cnt, j_ks_cnt);
    end
    checks++;
    if (returnvalue !== 32'hCAFE_0001) begin
      errors++; $display("FAIL full_ret: got %h expected cafe0001", returnvalue);
    end
  endtask

  task automatic test_partial_wrap;
    run_job(64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_FFF8, 5, 3, 8, KM_INC, 32'h5, 0);
    checks++;
    if (j_err !== 0 || j_wr_cnt != 3 || j_fr_cnt != 4 || j_fw_cnt != 2) begin
      errors++;
      $display("FAIL partial_status: got err %0d wr %0d fr %0d fw %0d expected 0 3 4 2",
               j_err, j_wr_cnt, j_fr_cnt, j_fw_cnt);
    end
  endtask

  task automatic test_bad_count;
    logic [63:0] nr_tab [3];
    logic [63:0] nw_tab [3];
    nr_tab[0] = 9; nw_tab[0] = 8;
    nr_tab[1] = 0; nw_tab[1] = 4;
    nr_tab[2] = 4; nw_tab[2] = 9;
    for (int i = 0; i < 3; i++) begin
      run_job(64'h2000, 64'h3000, nr_tab[i], nw_tab[i], 4, KM_RET, 32'hDEAD_BEEF, 0);
      checks++;
      if (j_done_cyc != 2 || j_err !== 1) begin
        errors++;
        $display("FAIL bad_count[%0d]: got done cyc %0d err %0d expected 2 1", i, j_done_cyc, j_err);
      end
      checks++;
      if (j_first_rd != -1 || j_we_seen != 0 || returnvalue !== last_ret) begin
        errors++;
        $display("FAIL bad_count_side[%0d]: got rd %0d we %0d ret %h expected -1 0 %h",
                 i, j_first_rd, j_we_seen, returnvalue, last_ret);
      end
    end
  endtask

  task automatic test_timeout;
    run_job(64'h4000, 64'h5000, 8, 8, 4, KM_NEVER, 32'h0, 0);
    checks++;
    if (j_err !== 1 || j_kstart_cyc < 0 || j_done_cyc != j_kstart_cyc + TO + 1) begin
      errors++;
      $display("FAIL timeout: got err %0d done %0d kstart %0d expected err 1 done kstart+%0d",
               j_err, j_done_cyc, j_kstart_cyc, TO + 1);
    end
    checks++;
    if (j_we_seen != 0 || returnvalue !== last_ret) begin
      errors++;
      $display("FAIL timeout_side: got we %0d ret %h expected 0 %h", j_we_seen, returnvalue, last_ret);
    end
  endtask

  task automatic test_dual_write;
    run_job(64'h6000, 64'h7000, 8, 8, 4, KM_DUAL, 32'h77, 0);
    checks++;
    if (j_err !== 0 || j_wr_cnt != 8) begin
      errors++; $display("FAIL dual_status: got err %0d wr %0d expected 0 8", j_err, j_wr_cnt);
    end
  endtask

  task automatic test_reset_mid;
    run_job(64'h9000, 64'hA000, 8, 8, 4, KM_INC, 32'h99, 3);
    checks++;
    if (j_aborted != 1) begin
      errors++; $display("FAIL mid_abort: got %0d expected 1", j_aborted);
    end
    @(negedge clk);
    reset_n = 1'b1;
    checks++;
    if ({read_enable, write_enable, finish_read, finish_write, done, error, busy, k_start} !== 8'h0 ||
        {read_addr, write_addr, write_size, read_size_output} !== 256'h0 ||
        {write_data, returnvalue, k_q0, k_q1} !== 128'h0) begin
      errors++;
      $display("FAIL mid_reset_state: got re %b busy %b ra %h ret %h expected all 0",
               read_enable, busy, read_addr, returnvalue);
    end
    last_ret = '0;
    exp_q.delete();
    run_job(64'hB000, 64'hC000, 8, 8, 4, KM_INC, 32'hABCD, 0);
    checks++;
    if (j_err !== 0 || j_wr_cnt != 8 || returnvalue !== 32'hABCD) begin
      errors++;
      $display("FAIL post_reset_job: got err %0d wr %0d ret %h expected 0 8 abcd", j_err, j_wr_cnt, returnvalue);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 2; i++) begin
      run_job(64'hD000, 64'hE000, 2, 0, 4, KM_RET, 32'h1234, 0);
      checks++;
      if (j_err !== 0 || j_we_seen != 0 || returnvalue !== 32'h1234) begin
        errors++;
        $display("FAIL b2b[%0d]: got err %0d we %0d ret %h expected 0 0 1234", i, j_err, j_we_seen, returnvalue);
      end
      checks++;
      if (j_done_cyc != j_kdone_cyc + 1) begin
        errors++;
        $display("FAIL b2b_latency[%0d]: got %0d expected %0d", i, j_done_cyc, j_kdone_cyc + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_job();
    test_partial_wrap();
    test_bad_count();
    test_timeout();
    test_dual_write();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/kernel_dma_shell.md
# kernel_dma_shell

Parametrised streaming shell that loads a job's operands from the memory read channel into a local dual-port buffer, runs an attached HLS kernel (ap_start/ap_done, two buffer ports with read and write), then streams the buffer back out through the write channel. It generalises the fixed 8-word, 32-bit, read-only-kernel motion shell. New over that shell: configurable width and depth, kernel write-back into the buffer, independent read and write counts, an explicit start, re-arming after completion, and error/timeout reporting.

## Interface
- DATA_WID, 32, data word width
- ADDR_WID, 3, buffer address width; DEPTH = 2^ADDR_WID words
- TIMEOUT, 0, maximum kernel run cycles; 0 disables the timeout
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low)
- start  in  1  job start request, sampled in IDLE only
- read_base, write_base  in  64  first read and write addresses
- num_read, num_write  in  64  words to load and words to store
- read_size_input  in  64  word stride in bytes, used for reads and writes
- read_ready, write_ready  in  1  memory channel accept/valid strobes
- read_data  in  DATA_WID  read word
- read_enable, write_enable, finish_read, finish_write  out  1  memory channel controls
- read_addr, write_addr, write_size, read_size_output  out  64  channel address and size
- write_data  out  DATA_WID  write word
- done  out  1  one-cycle completion pulse
- error  out  1  one-cycle pulse coincident with done on a failed job
- busy  out  1  high in every state except IDLE
- returnvalue  out  DATA_WID  kernel result latched on k_done
- k_start  out  1; k_done  in  1; k_ret  in  DATA_WID  kernel control and result
- k_addr0/k_addr1  in  ADDR_WID; k_ce0/k_ce1, k_we0/k_we1  in  1; k_d0/k_d1  in  DATA_WID; k_q0/k_q1  out  DATA_WID  kernel buffer ports

## Operation
- States: IDLE, CHECK, RD_WAIT, RD_NEXT, K_START, K_RUN, WR_LOAD, WR_WAIT, WR_NEXT, FIN.
- IDLE: if start=1, latch all job inputs and go to CHECK. start is ignored in every other state.
- CHECK: if num_read=0, num_read>DEPTH or num_write>DEPTH, go to FIN with an error flag. Otherwise set read_addr=read_base, read_size_output=read_size_input, read_enable=1, cnt=0, and go to RD_WAIT.
- RD_WAIT: finish_read=0. On read_ready=1, buf[cnt]<=read_data and go to RD_NEXT.
- RD_NEXT: if cnt+1<num_read, then cnt++, read_addr+=stride, finish_read=1 for one cycle, and return to RD_WAIT. Otherwise read_enable=0 and go to K_START.
- K_START: k_start=1 for exactly one cycle, then go to K_RUN.
- K_RUN:
  - Each port p, when k_cep=1: if k_wep=1, buf[k_addrp]<=k_dp; otherwise k_qp<=buf[k_addrp].
  - When both ports write the same address in the same cycle, port 1 wins.
  - Reading and writing the same address in one cycle returns the old data.
  - On k_done=1: returnvalue<=k_ret. If num_write=0, go to FIN; otherwise go to WR_LOAD.
  - If TIMEOUT≠0 and the run cycle counter reaches TIMEOUT without k_done, go to FIN with the error flag; returnvalue is unchanged.
- WR_LOAD: write_addr=write_base, write_size=read_size_input, write_data=buf[0], write_enable=1, cnt=0, then go to WR_WAIT.
- WR_WAIT: finish_write=0. On write_ready=1, go to WR_NEXT.
- WR_NEXT: if cnt+1<num_write, then cnt++, write_data=buf[cnt+1], write_addr+=stride, finish_write=1, and return to WR_WAIT. Otherwise write_enable=0 and go to FIN.
- FIN: done=1 (and error=1 if flagged) for one cycle. Clear all channel outputs, then go to IDLE, which re-arms the block. Buffer contents persist.
- Address arithmetic is 64-bit and wraps modulo 2^64 without detection.

## Timing
- Reset (reset_n=0 at a clk edge), from any state including mid-transfer: state=IDLE; all 1-bit outputs 0; all address/size outputs 0; write_data, returnvalue, k_q0 and k_q1 are 0. The buffer is not cleared.
- Read-back latency on a kernel port is 1 cycle: ce at edge n gives q valid after edge n.
- Minimum cycles per read word is 2 (RD_WAIT + RD_NEXT), and likewise per write word.
- The first read_enable rises 2 cycles after start is sampled.
- done follows the final write_ready by 2 cycles, or k_done by 1 cycle when num_write=0.
- An error job asserts done/error 2 cycles after start.
- read_ready is ignored outside RD_WAIT; write_ready is ignored outside WR_WAIT; k_done is ignored outside K_RUN.

## Test plan
- Defaults, num_read=8, num_write=8, stride 4; kernel reads words 0..7 and writes buf[i]=buf[i]+1 -> write data equals input+1 at addresses write_base+4i, one done pulse, error=0.
- num_read=DEPTH+1 -> no read_enable, done=error=1 at cycle start+2, returnvalue unchanged.
- TIMEOUT=50 with a kernel that never raises k_done -> done=error=1 after 50 K_RUN cycles, write_enable never asserted.
- Both kernel ports write address 3 (values A and B) in the same cycle -> written-back word 3 equals B.
- reset_n low for one cycle during RD_WAIT, then a new start -> all outputs 0, then a clean full job completes.
- Two back-to-back jobs with num_write=0 and k_ret=0x1234 -> returnvalue=0x1234, two done pulses, write_enable stays 0, busy low between jobs.
